// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and request/response types for the data-memory arbiter
package dmem_pkg;
  localparam int unsigned DEPTH_DEF = 200;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;
  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;
  typedef struct packed {
    logic              rvalid;
    logic              err;
    logic [DW_DEF-1:0] rdata;
  } rsp_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; the pointer favours the requester not granted last
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);
  logic       ptr_q, ptr_d;
  logic [1:0] cand;
  // pick among eligible requests; a tie goes to the pointer, then the pointer flips away from the winner
  always_comb begin
    cand  = req_i & elig_i;
    gnt_o = &cand ? (ptr_q ? 2'b10 : 2'b01) : cand;
    ptr_d = gnt_o[0] ? 1'b1 : gnt_o[1] ? 1'b0 : ptr_q;
  end
  // pointer register; 0 favours requester 0
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one word-addressed data memory between the CPU and DMA requesters
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int          AW    = AW_DEF,
  parameter int          DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);
  logic [1:0] pick, gnt;
  req_t       cand [2];
  req_t       iss_q, iss_d;
  logic       iss_v_q, iss_src_q, in_range;
  rsp_t       rsp_q [2], rsp_d [2];

  // a port that is being granted this cycle still holds its old request, so it must sit out one pick
  assign gnt = {iss_v_q & iss_src_q, iss_v_q & ~iss_src_q};
  assign cand[REQ_CPU] = '{we: we0, addr: addr0, wdata: wdata0};
  assign cand[REQ_DMA] = '{we: we1, addr: addr1, wdata: wdata1};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({req1, req0}),
    .elig_i (~gnt),
    .gnt_o  (pick)
  );

  assign iss_d     = |pick ? cand[pick[REQ_DMA]] : iss_q;
  assign in_range  = iss_q.addr < AW'(DEPTH);
  assign mem_addr  = iss_q.addr;
  assign mem_wdata = iss_q.wdata;
  assign mem_read  = iss_v_q & ~iss_q.we & in_range;
  assign mem_write = iss_v_q & iss_q.we & in_range;
  assign gnt0      = gnt[REQ_CPU];
  assign gnt1      = gnt[REQ_DMA];

  // issue register: the winner is driven to memory for exactly one cycle; address/data hold when idle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      iss_v_q   <= 1'b0;
      iss_src_q <= 1'b0;
      iss_q     <= '0;
    end else begin
      iss_v_q   <= |pick;
      iss_src_q <= pick[REQ_DMA];
      iss_q     <= iss_d;
    end

  // response next-state: reads capture memory data, out-of-range accesses return zero with err
  always_comb begin
    rsp_d = rsp_q;
    for (int i = 0; i < 2; i++) begin
      rsp_d[i].rvalid = gnt[i];
      rsp_d[i].err    = gnt[i] & ~in_range;
      if (gnt[i] & (~iss_q.we | ~in_range)) rsp_d[i].rdata = in_range ? mem_rdata : '0;
    end
  end

  // response registers per port
  always_ff @(posedge clk or posedge rst)
    if (rst) rsp_q <= '{default: '0};
    else     rsp_q <= rsp_d;

  assign rvalid0 = rsp_q[REQ_CPU].rvalid;
  assign rvalid1 = rsp_q[REQ_DMA].rvalid;
  assign err0    = rsp_q[REQ_CPU].err;
  assign err1    = rsp_q[REQ_DMA].err;
  assign rdata0  = rsp_q[REQ_CPU].rdata;
  assign rdata1  = rsp_q[REQ_DMA].rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, pipeline timing, range errors and async reset
module tb_dmem_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_write, mem_read;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [200];
  int          n_cmp = 0, n_fail = 0, n_gnt;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 200) ? mem[mem_addr[7:0]] : 32'd0;

  always @(posedge clk)
    if (mem_write && mem_addr < 200) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 200; i++) mem[i] <= 32'd0;
    mem[2] <= 32'd100;
    mem[3] <= 32'd200;
    tick; tick;
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_err", {err1, err0}, 0);
    chk("rst_strobes", {mem_write, mem_read}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    rst = 0;
    // single read on port 0
    req0 = 1; we0 = 0; addr0 = 2;
    tick;
    chk("rd0_gnt", {gnt1, gnt0}, 2'b01);
    chk("rd0_mem_read", {mem_write, mem_read}, 2'b01);
    chk("rd0_mem_addr", mem_addr, 2);
    req0 = 0;
    tick;
    chk("rd0_gnt_off", {gnt1, gnt0}, 0);
    chk("rd0_rvalid", {rvalid1, rvalid0}, 2'b01);
    chk("rd0_err", err0, 0);
    chk("rd0_rdata", rdata0, 100);
    // write then read back on port 1
    req1 = 1; we1 = 1; addr1 = 5; wdata1 = 32'hDEADBEEF;
    tick;
    chk("wr1_gnt", {gnt1, gnt0}, 2'b10);
    chk("wr1_mem_write", {mem_write, mem_read}, 2'b10);
    chk("wr1_mem_addr", mem_addr, 5);
    chk("wr1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    we1 = 0;
    tick;
    chk("wr1_rvalid", {rvalid1, rvalid0}, 2'b10);
    chk("wr1_err", err1, 0);
    chk("wr1_rdata_held", rdata1, 0);
    chk("wr1_no_regrant", gnt1, 0);
    chk("wr1_stored", mem[5], 32'hDEADBEEF);
    tick;
    chk("rd1_gnt", {gnt1, gnt0}, 2'b10);
    chk("rd1_mem_read", {mem_write, mem_read}, 2'b01);
    req1 = 0;
    tick;
    chk("rd1_rvalid", rvalid1, 1);
    chk("rd1_rdata", rdata1, 32'hDEADBEEF);
    // both held: strict alternation starting with port 0
    req0 = 1; addr0 = 2; req1 = 1; addr1 = 3;
    tick;
    chk("alt1_gnt", {gnt1, gnt0}, 2'b01);
    chk("alt1_addr", mem_addr, 2);
    tick;
    chk("alt2_gnt", {gnt1, gnt0}, 2'b10);
    chk("alt2_addr", mem_addr, 3);
    chk("alt2_rvalid", {rvalid1, rvalid0}, 2'b01);
    chk("alt2_rdata0", rdata0, 100);
    tick;
    chk("alt3_gnt", {gnt1, gnt0}, 2'b01);
    chk("alt3_rvalid", {rvalid1, rvalid0}, 2'b10);
    chk("alt3_rdata1", rdata1, 200);
    tick;
    chk("alt4_gnt", {gnt1, gnt0}, 2'b10);
    chk("alt4_mem_read", mem_read, 1);
    req0 = 0; req1 = 0;
    tick;
    chk("alt_drain_gnt", {gnt1, gnt0}, 0);
    chk("alt_drain_read", mem_read, 0);
    tick;
    // port 0 held alone: one grant every other cycle
    req0 = 1; addr0 = 3;
    n_gnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk($sformatf("solo_gnt_c%0d", c), gnt0, (c % 2 == 0) ? 1 : 0);
      chk($sformatf("solo_read_c%0d", c), mem_read, (c % 2 == 0) ? 1 : 0);
      n_gnt += gnt0 ? 1 : 0;
    end
    chk("solo_count", n_gnt, 3);
    req0 = 0;
    tick;
    // out-of-range reads
    req0 = 1; addr0 = 200;
    tick;
    chk("oor1_gnt", gnt0, 1);
    chk("oor1_strobes", {mem_write, mem_read}, 0);
    addr0 = 32'hFFFFFFFF;
    tick;
    chk("oor1_rvalid_err", {rvalid0, err0}, 2'b11);
    chk("oor1_rdata", rdata0, 0);
    tick;
    chk("oor2_gnt", gnt0, 1);
    chk("oor2_strobes", {mem_write, mem_read}, 0);
    req0 = 0;
    tick;
    chk("oor2_rvalid_err", {rvalid0, err0}, 2'b11);
    chk("oor2_rdata", rdata0, 0);
    tick;
    // pointer now favours port 1; a reset pulse must bring it back to port 0
    #2 rst = 1;
    #2 rst = 0;
    req0 = 1; addr0 = 2; req1 = 1; addr1 = 3;
    tick;
    chk("prst_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 0;
    tick;
    chk("prst_gnt2", {gnt1, gnt0}, 2'b10);
    chk("prst_rdata0", rdata0, 100);
    req1 = 0;
    tick;
    chk("prst_rdata1", rdata1, 200);
    tick;
    // reset while a write sits in the issue stage
    req1 = 1; we1 = 1; addr1 = 7; wdata1 = 55;
    tick;
    chk("rstw_gnt", gnt1, 1);
    chk("rstw_mem_write", mem_write, 1);
    #2 rst = 1;
    #1;
    chk("rstw_gnt_clr", {gnt1, gnt0}, 0);
    chk("rstw_strobes_clr", {mem_write, mem_read}, 0);
    chk("rstw_addr_clr", mem_addr, 0);
    chk("rstw_wdata_clr", mem_wdata, 0);
    chk("rstw_rdata_clr", {rdata0, rdata1}, 0);
    req1 = 0; we1 = 0;
    tick;
    chk("rstw_rvalid_lost", {rvalid1, rvalid0}, 0);
    chk("rstw_mem7", mem[7], 0);
    rst = 0;
    req0 = 1; addr0 = 2; req1 = 1; addr1 = 3;
    tick;
    chk("post_first_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 0;
    tick;
    chk("post_second_gnt", {gnt1, gnt0}, 2'b10);
    req1 = 0;
    tick;
    chk("post_rdata1", rdata1, 200);
    chk("post_mem7", mem[7], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
